uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Byte buffer directly downstream of the UART receiver. Captures each received byte
//  on the receiver's one-cycle data-available strobe and stores it in a circular FIFO.
//  Presents bytes to a consumer (display/command logic) over a valid/ready handshake
//  in first-word-fall-through form, so back-to-back UART bytes are never lost while
//  the consumer is busy.
// PARAMETERS
//  DEPTH      16   FIFO entries; must be a power of 2, >= 2
//  ADDR_W     4    pointer width = log2(DEPTH); must match DEPTH
// PORTS
//  clk          in   1        system clock (100 MHz on Basys3)
//  i_rst_n      in   1        asynchronous active-low reset
//  i_rx_byte    in   8        received byte from UART receiver
//  i_rx_valid   in   1        one-cycle strobe: i_rx_byte is valid this cycle
//  o_data       out  8        head-of-FIFO byte (valid only while o_valid=1)
//  o_valid      out  1        FIFO not empty; o_data holds oldest byte
//  i_ready      in   1        consumer accepts o_data this cycle
//  o_count      out  ADDR_W+1 entries currently stored (0..DEPTH)
//  o_full       out  1        o_count == DEPTH
//  o_empty      out  1        o_count == 0
//  o_overflow   out  1        sticky: a byte was dropped because FIFO was full
//  i_clr_ovf    in   1        one-cycle pulse clears o_overflow
// BEHAVIOUR
//  - Reset (async assert, sync-released use): wr_ptr=rd_ptr=0, o_count=0, o_empty=1,
//    o_full=0, o_valid=0, o_overflow=0, o_data=8'h00. Reset mid-transfer discards contents.
//  - Push: i_rx_valid=1 and (not full, or pop in same cycle) -> mem[wr_ptr]<=i_rx_byte,
//    wr_ptr<=wr_ptr+1 (wraps DEPTH-1 -> 0).
//  - Pop: o_valid && i_ready -> rd_ptr<=rd_ptr+1 (wraps). i_ready with o_valid=0 ignored.
//  - FWFT latency: byte pushed at edge N appears on o_data with o_valid=1 after edge N
//    when FIFO was empty (one cycle). o_data always reflects mem[rd_ptr], registered.
//  - o_count: +1 push only, -1 pop only, unchanged for push+pop or neither.
//    o_full/o_empty/o_valid are registered, derived from next count; no comb paths
//    from i_ready or i_rx_valid to any output.
//  - Simultaneous push+pop when full: both happen, count stays DEPTH, no overflow.
//  - Simultaneous push+pop when empty: pop is not possible (o_valid=0); push only.
//  - Overflow: push while full and no pop -> byte dropped, pointers/count unchanged,
//    o_overflow<=1 (sticky). i_clr_ovf clears it; if clear and new overflow occur in
//    the same cycle, o_overflow stays 1.
//  - Counter arithmetic: pointers ADDR_W bits, natural wrap; count ADDR_W+1 bits,
//    never exceeds DEPTH nor underflows.
// CONFIGURATION
//  UART_RX_FIFO_LINE_DETECT_EN defined:
//   - extra outputs o_line_cnt [ADDR_W:0] and o_line_ready [1]. o_line_cnt increments
//     when a byte 8'h0A ('\n') is pushed, decrements when 8'h0A is popped (both same
//     cycle: unchanged); o_line_ready = (o_line_cnt != 0), registered; reset 0.
//     Dropped (overflow) 8'h0A bytes are not counted.
//  Not defined: ports absent, no line-tracking logic; FIFO behaviour identical.
// TESTING
//  1 Reset: drive i_rst_n=0 mid-run -> all outputs at reset values immediately
//    (async), o_empty=1, o_count=0.
//  2 Single byte: push 8'h41 with i_ready=0 -> next cycle o_valid=1, o_data=8'h41,
//    o_count=1; assert i_ready one cycle -> o_valid=0, o_empty=1.
//  3 Fill/order: push 0x00..0x0F (DEPTH=16) -> o_full=1, o_count=16; drain with
//    i_ready=1 -> bytes emerge 0x00..0x0F in order, then o_empty=1.
//  4 Overflow: full FIFO, push 8'hFF with i_ready=0 -> o_overflow=1, o_count=16,
//    8'hFF never output; pulse i_clr_ovf -> o_overflow=0 next cycle.
//  5 Full push+pop: full FIFO, push 8'h55 with i_ready=1 same cycle -> o_count stays 16,
//    o_overflow=0, 8'h55 is 16th byte out; wrap: 40 push/pop pairs, data intact.
//  6 Line detect (macro on): push "DALHA\n" -> o_line_cnt=1, o_line_ready=1; pop six
//    bytes -> o_line_cnt=0 after the 8'h0A pop; macro off build compiles without ports.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte buffer between the UART receiver and its consumer.
//
// Captures each received byte on the receiver's one-cycle strobe into a
// circular FIFO. Bytes are presented first-word-fall-through over a
// valid/ready handshake. All outputs are registered, so there is no
// combinational path from i_ready or i_rx_valid to any output.
//
// Optional feature: define UART_RX_FIFO_LINE_DETECT_EN to add newline
// (8'h0A) tracking through o_line_cnt / o_line_ready.
//
// Ports:
//   clk          system clock
//   i_rst_n      asynchronous active-low reset
//   i_rx_byte    received byte
//   i_rx_valid   one-cycle strobe, i_rx_byte valid
//   o_data       head-of-FIFO byte, meaningful while o_valid = 1
//   o_valid      FIFO not empty
//   i_ready      consumer takes o_data this cycle
//   o_count      entries stored, 0..DEPTH
//   o_full       o_count == DEPTH
//   o_empty      o_count == 0
//   o_overflow   sticky: a byte was dropped because the FIFO was full
//   o_line_cnt   (optional) number of 8'h0A bytes stored
//   o_line_ready (optional) o_line_cnt != 0
//   i_clr_ovf    one-cycle pulse clearing o_overflow
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_valid,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
`ifdef UART_RX_FIFO_LINE_DETECT_EN
  output logic [ADDR_W:0]   o_line_cnt,
  output logic              o_line_ready,
`endif
  input  logic              i_clr_ovf
);

  localparam logic [ADDR_W:0]   CntFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, full_q, empty_q, ovf_q, ovf_d;
  logic              push, pop, ovf_evt;

  always_comb begin
    pop      = valid_q & i_ready;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    push     = i_rx_valid & (~full_q | pop);
    ovf_evt  = i_rx_valid & full_q & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    // Bypass: when the new head is the slot being written this cycle, the
    // memory does not hold the byte yet, so take it straight from the input.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      data_d = i_rx_byte;
    end else begin
      data_d = mem_q[rd_ptr_d];
    end

    // A new overflow wins over a simultaneous clear.
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_rx_byte;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= (count_d != '0);
      full_q   <= (count_d == CntFull);
      empty_q  <= (count_d == '0);
      ovf_q    <= ovf_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_overflow = ovf_q;

`ifdef UART_RX_FIFO_LINE_DETECT_EN
  logic [ADDR_W:0] line_cnt_q, line_cnt_d;
  logic            line_ready_q;
  logic            line_inc, line_dec;

  always_comb begin
    // Dropped newlines never reach memory, so only accepted pushes count.
    line_inc   = push & (i_rx_byte == 8'h0A);
    line_dec   = pop & (data_q == 8'h0A);
    line_cnt_d = line_cnt_q;
    unique case ({line_inc, line_dec})
      2'b10:   line_cnt_d = line_cnt_q + CntOne;
      2'b01:   line_cnt_d = line_cnt_q - CntOne;
      default: line_cnt_d = line_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_cnt_q   <= '0;
      line_ready_q <= 1'b0;
    end else begin
      line_cnt_q   <= line_cnt_d;
      line_ready_q <= (line_cnt_d != '0);
    end
  end

  assign o_line_cnt   = line_cnt_q;
  assign o_line_ready = line_ready_q;
`endif

endmodule
